mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb.sv | 156 +++++++++++++++
 tb/tb_mem_arb.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// mem_arb: three-way arbiter in front of a single-port synchronous RAM.
//
// Requesters: host loader (always highest priority), CPU data port (d) and
// instruction fetch port (if, read-only). Only IDLE accepts a request; the grant
// is combinational in the same cycle and the winner's address/data/mask go
// straight to the RAM. A write finishes in its grant cycle. A read moves to RESP,
// where the owner's rvalid is raised for one cycle with rsp_rdata = ram_rdata.
//
// Optional feature: MEM_ARB_RR_EN. When defined, d and if share the lower
// priority slot round-robin (the last granted of the two loses a tie). When
// undefined, d always beats if. The host stays highest in both builds.
//
// Ports:
//   clock, reset                           single clock, synchronous active-high reset
//   host_req/we/addr/wdata/wbmask          host loader request
//   d_req/we/addr/wdata/wbmask             CPU data request
//   if_req/if_addr                         instruction fetch request
//   host_gnt, d_gnt, if_gnt                request accepted this cycle
//   host_rvalid, d_rvalid, if_rvalid       read data valid (one-hot or zero)
//   rsp_rdata                              shared read data, zero when no rvalid
//   ram_wen/wbmask/addr/wdata, ram_rdata   RAM port, read data one cycle after addr
module mem_arb #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic [3:0]        host_wbmask,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_wbmask,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              host_gnt,
    output logic              d_gnt,
    output logic              if_gnt,
    output logic              host_rvalid,
    output logic              d_rvalid,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              ram_wen,
    output logic [3:0]        ram_wbmask,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic {StIdle, StResp} state_e;
    typedef enum logic [1:0] {OwnNone, OwnHost, OwnD, OwnIf} owner_e;

    state_e state_q, state_d;
    owner_e owner_q, owner_d;
    logic   pick_d;

`ifdef MEM_ARB_RR_EN
    // Set when d won the most recent d/if grant, so if wins the next tie.
    logic last_d_q, last_d_d;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        host_gnt    = 1'b0;
        d_gnt       = 1'b0;
        if_gnt      = 1'b0;
        host_rvalid = 1'b0;
        d_rvalid    = 1'b0;
        if_rvalid   = 1'b0;
        rsp_rdata   = '0;
        ram_wen     = 1'b0;
        ram_wbmask  = '0;
        ram_addr    = '0;
        ram_wdata   = '0;
`ifdef MEM_ARB_RR_EN
        last_d_d    = last_d_q;
        pick_d      = d_req && (!if_req || !last_d_q);
`else
        pick_d      = d_req;
`endif

        // Outputs are forced quiet during reset; that also drops an in-flight response.
        if (!reset) begin
            unique case (state_q)
                StIdle: begin
                    if (host_req) begin
                        host_gnt   = 1'b1;
                        ram_wen    = host_we;
                        ram_wbmask = host_wbmask;
                        ram_addr   = host_addr;
                        ram_wdata  = host_wdata;
                        if (!host_we) begin
                            state_d = StResp;
                            owner_d = OwnHost;
                        end
                    end else if (pick_d) begin
                        d_gnt      = 1'b1;
                        ram_wen    = d_we;
                        ram_wbmask = d_wbmask;
                        ram_addr   = d_addr;
                        ram_wdata  = d_wdata;
`ifdef MEM_ARB_RR_EN
                        last_d_d   = 1'b1;
`endif
                        if (!d_we) begin
                            state_d = StResp;
                            owner_d = OwnD;
                        end
                    end else if (if_req) begin
                        if_gnt   = 1'b1;
                        ram_addr = if_addr;
`ifdef MEM_ARB_RR_EN
                        last_d_d = 1'b0;
`endif
                        state_d  = StResp;
                        owner_d  = OwnIf;
                    end
                end
                StResp: begin
                    rsp_rdata = ram_rdata;
                    unique case (owner_q)
                        OwnHost: host_rvalid = 1'b1;
                        OwnD:    d_rvalid    = 1'b1;
                        OwnIf:   if_rvalid   = 1'b1;
                        default: rsp_rdata   = '0;
                    endcase
                    state_d = StIdle;
                    owner_d = OwnNone;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            owner_q  <= OwnNone;
`ifdef MEM_ARB_RR_EN
            last_d_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
`ifdef MEM_ARB_RR_EN
            last_d_q <= last_d_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
module tb_mem_arb;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam logic [1:0] WHO_HOST = 2'd0;
    localparam logic [1:0] WHO_D    = 2'd1;
    localparam logic [1:0] WHO_IF   = 2'd2;

    logic          clock = 1'b0;
    logic          reset;
    logic          host_req, host_we, d_req, d_we, if_req;
    logic [AW-1:0] host_addr, d_addr, if_addr;
    logic [DW-1:0] host_wdata, d_wdata;
    logic [3:0]    host_wbmask, d_wbmask;
    logic          host_gnt, d_gnt, if_gnt;
    logic          host_rvalid, d_rvalid, if_rvalid;
    logic [DW-1:0] rsp_rdata;
    logic          ram_wen;
    logic [3:0]    ram_wbmask;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  who;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] mem [64];

    always #5 clock = ~clock;

    mem_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock       (clock),
        .reset       (reset),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_wbmask (host_wbmask),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_wbmask    (d_wbmask),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .host_gnt    (host_gnt),
        .d_gnt       (d_gnt),
        .if_gnt      (if_gnt),
        .host_rvalid (host_rvalid),
        .d_rvalid    (d_rvalid),
        .if_rvalid   (if_rvalid),
        .rsp_rdata   (rsp_rdata),
        .ram_wen     (ram_wen),
        .ram_wbmask  (ram_wbmask),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    // Synchronous RAM model: byte-masked write, registered read.
    always @(posedge clock) begin
        if (ram_wen) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_wbmask[b]) mem[ram_addr[7:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
            end
        end
        ram_rdata <= mem[ram_addr[7:2]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] who, input logic [31:0] data);
        exp_t e;
        e.who  = who;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: pops the scoreboard whenever any rvalid is seen.
    always @(negedge clock) begin
        logic [2:0] rv;
        exp_t e;
        rv = {host_rvalid, d_rvalid, if_rvalid};
        if (rv != 3'b000) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rvalid", {29'd0, rv}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rvalid_owner", {29'd0, rv}, 32'd1 << (2 - e.who));
                chk("rsp_rdata", rsp_rdata, e.data);
            end
        end else if (!reset) begin
            chk("rsp_rdata_idle_zero", rsp_rdata, 32'd0);
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drop_all();
        host_req = 1'b0; host_we = 1'b0; d_req = 1'b0; d_we = 1'b0; if_req = 1'b0;
        host_wbmask = 4'h0; d_wbmask = 4'h0;
    endtask

    task automatic chk_gnt(input string name, input logic [2:0] exp);
        chk(name, {29'd0, host_gnt, d_gnt, if_gnt}, {29'd0, exp});
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0] = 32'h0010_0093;
        mem[2] = 32'hAABB_CCDD;
        host_addr = '0; host_wdata = '0; d_addr = '0; d_wdata = '0; if_addr = '0;
        drop_all();
        reset = 1'b1;

        // Reset cycle with requests pending: everything quiet.
        host_req = 1'b1; d_req = 1'b1; if_req = 1'b1;
        #1;
        @(negedge clock);
        chk_gnt("reset_gnt", 3'b000);
        chk("reset_wen", {31'd0, ram_wen}, 32'd0);
        chk("reset_rvalid", {29'd0, host_rvalid, d_rvalid, if_rvalid}, 32'd0);
        next_cycle();

        // First cycle after reset: host write beats d and if.
        reset = 1'b0;
        host_req = 1'b1; host_we = 1'b1; host_addr = 32'h10;
        host_wdata = 32'hDEAD_BEEF; host_wbmask = 4'hF;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0; if_req = 1'b1; if_addr = 32'h0;
        @(negedge clock);
        chk_gnt("host_write_gnt", 3'b100);
        chk("host_write_wen", {31'd0, ram_wen}, 32'd1);
        chk("host_write_addr", ram_addr, 32'h10);
        chk("host_write_wdata", ram_wdata, 32'hDEAD_BEEF);
        chk("host_write_mask", {28'd0, ram_wbmask}, 32'hF);
        next_cycle();

        // Idle: nothing requested.
        drop_all();
        @(negedge clock);
        chk_gnt("idle_gnt", 3'b000);
        chk("idle_wen_mask", {27'd0, ram_wen, ram_wbmask}, 32'd0);
        next_cycle();

        // Instruction fetch read, request held through RESP.
        if_req = 1'b1; if_addr = 32'h0;
        @(negedge clock);
        chk_gnt("if_read_gnt", 3'b001);
        chk("if_read_wen", {31'd0, ram_wen}, 32'd0);
        push(WHO_IF, 32'h0010_0093);
        next_cycle();
        @(negedge clock);
        chk_gnt("if_resp_gnt", 3'b000);
        next_cycle();
        drop_all();
        next_cycle();

        // d read of the host-written word.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        @(negedge clock);
        chk_gnt("d_read_gnt", 3'b010);
        push(WHO_D, 32'hDEAD_BEEF);
        next_cycle();
        drop_all();
        next_cycle();

        // Partial write then immediate read-back.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_wdata = 32'h1122_3344; d_wbmask = 4'h3;
        @(negedge clock);
        chk_gnt("d_write_gnt", 3'b010);
        chk("d_write_mask", {27'd0, ram_wen, ram_wbmask}, 32'h13);
        next_cycle();
        d_we = 1'b0; d_wbmask = 4'h0;
        @(negedge clock);
        chk_gnt("d_readback_gnt", 3'b010);
        push(WHO_D, 32'hAABB_3344);
        next_cycle();
        drop_all();
        next_cycle();

        // Reset, then d and if contend with held read requests.
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; if_req = 1'b1; if_addr = 32'h0;
        for (int k = 0; k < 4; k++) begin
            logic exp_d;
`ifdef MEM_ARB_RR_EN
            exp_d = (k % 2) == 0;
`else
            exp_d = 1'b1;
`endif
            @(negedge clock);
            chk_gnt("contend_gnt", exp_d ? 3'b010 : 3'b001);
            if (exp_d) push(WHO_D, 32'hDEAD_BEEF);
            else       push(WHO_IF, 32'h0010_0093);
            next_cycle();
            @(negedge clock);
            chk_gnt("contend_resp_gnt", 3'b000);
            next_cycle();
        end
        drop_all();
        next_cycle();

        // Reset while a d read is in flight: response is dropped.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        @(negedge clock);
        chk_gnt("abort_read_gnt", 3'b010);
        next_cycle();
        drop_all();
        reset = 1'b1;
        @(negedge clock);
        chk("abort_rvalid_n1", {31'd0, d_rvalid}, 32'd0);
        next_cycle();
        reset = 1'b0;
        if_req = 1'b1; if_addr = 32'h0;
        @(negedge clock);
        chk("abort_rvalid_n2", {31'd0, d_rvalid}, 32'd0);
        chk_gnt("abort_idle_gnt", 3'b001);
        push(WHO_IF, 32'h0010_0093);
        next_cycle();
        drop_all();
        next_cycle();

        // Host read beats a pending d request.
        host_req = 1'b1; host_we = 1'b0; host_addr = 32'h8; d_req = 1'b1; d_we = 1'b1;
        @(negedge clock);
        chk_gnt("host_read_gnt", 3'b100);
        push(WHO_HOST, 32'hAABB_3344);
        next_cycle();
        drop_all();
        next_cycle();

        // Back-to-back writes, one per cycle, then read the second back.
        d_req = 1'b1; d_we = 1'b1; d_wbmask = 4'hF; d_addr = 32'h20; d_wdata = 32'h1234_5678;
        @(negedge clock);
        chk_gnt("b2b_write0_gnt", 3'b010);
        next_cycle();
        d_addr = 32'h24; d_wdata = 32'hCAFE_F00D;
        @(negedge clock);
        chk_gnt("b2b_write1_gnt", 3'b010);
        chk("b2b_write1_addr", ram_addr, 32'h24);
        next_cycle();
        d_we = 1'b0; d_wbmask = 4'h0;
        @(negedge clock);
        chk_gnt("b2b_read_gnt", 3'b010);
        push(WHO_D, 32'hCAFE_F00D);
        next_cycle();
        drop_all();

        // Allow outstanding responses to drain within a bounded window.
        for (int w = 0; w < 8 && exp_q.size() != 0; w++) next_cycle();
        next_cycle();
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
